async_fifo_rd_ctrl: RTL and testbench

Read-side controller for the async FIFO, living entirely in the read clock domain. It pops words from the FIFO read port (`rinc`/`rdata`/`rempty`) and re-presents them on a valid/ready stream through a two-entry output buffer. This sustains one word per cycle under back-pressure. It also supports a flush that drains and discards all FIFO contents.

---
 rtl/async_fifo_rd_ctrl.sv | 91 +++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_ctrl.sv
// async_fifo_rd_ctrl: read-side controller for the async FIFO, re-presenting popped words on a valid/ready stream
//
// Pops words from the FIFO read port and holds them in a two-entry output
// buffer. The buffer keeps the stream running at one word per cycle under
// back-pressure. A flush request discards the buffer and drains the FIFO.
//
// Ports (all in the rclk domain):
//   rclk, r_rstn    clock and asynchronous active-low reset
//   rempty, rdata   FIFO empty flag and head word
//   almost_empty    FIFO almost-empty flag, registered out on low_water
//   rinc            FIFO pop strobe (combinational)
//   en, flush       stream enable and single-cycle flush request
//   m_data, m_valid, m_ready   output stream
//   flush_done      one-cycle pulse when a flush completes
//   low_water       registered copy of almost_empty
//   rd_cnt          delivered-word counter
//
// Optional feature: define FIFO_RD_CNT_EN to build the rd_cnt counter.
// Without it, rd_cnt is tied to zero.
module async_fifo_rd_ctrl #(
   parameter int DATESIZE = 8,
   parameter int CNT_W    = 16
) (
   input  logic                rclk,
   input  logic                r_rstn,
   input  logic                rempty,
   input  logic                almost_empty,
   input  logic [DATESIZE-1:0] rdata,
   output logic                rinc,
   input  logic                en,
   input  logic                flush,
   output logic [DATESIZE-1:0] m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                flush_done,
   output logic                low_water,
   output logic [CNT_W-1:0]    rd_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t              r_state;
   logic [1:0]          r_occ;
   logic [DATESIZE-1:0] r_buf [2];
   logic                w_xfer;
   logic                w_push;
   logic                w_tail;
   assign m_valid = (r_occ != 2'd0) && (r_state != FLUSH);
   assign m_data  = r_buf[0];
   assign w_xfer  = m_valid && m_ready;
   // A full buffer may only accept a word when its head leaves in the same cycle.
   assign w_push  = r_rstn && en && (r_state != FLUSH) && !rempty && ((r_occ != 2'd2) || w_xfer);
   assign rinc    = w_push || (r_rstn && (r_state == FLUSH) && !rempty);
   // Tail slot after any same-cycle shift: occ minus the departing head.
   assign w_tail  = r_occ[1] | (r_occ[0] & !w_xfer);
   always_ff @(posedge rclk or negedge r_rstn) begin
      if (!r_rstn) begin
         r_state    <= IDLE;
         r_occ      <= 2'd0;
         r_buf[0]   <= '0;
         r_buf[1]   <= '0;
         flush_done <= 1'b0;
         low_water  <= 1'b1;
      end else begin
         low_water  <= almost_empty;
         flush_done <= 1'b0;
         if (flush && (r_state != FLUSH)) begin
            r_state <= FLUSH;
            r_occ   <= 2'd0;
         end else if (r_state == FLUSH) begin
            if (rempty) begin
               flush_done <= 1'b1;
               r_state    <= en ? RUN : IDLE;
            end
         end else begin
            r_state <= en ? RUN : IDLE;
            r_occ   <= r_occ + {1'b0, w_push} - {1'b0, w_xfer};
            if (w_xfer) r_buf[0] <= r_buf[1];
            if (w_push) r_buf[w_tail] <= rdata;
         end
      end
   end
`ifdef FIFO_RD_CNT_EN
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge rclk or negedge r_rstn) begin
      if (!r_rstn) r_cnt <= '0;
      else if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
   end
   assign rd_cnt = r_cnt;
`else
   assign rd_cnt = '0;
`endif
endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// tb_async_fifo_rd_ctrl: directed self-checking bench for async_fifo_rd_ctrl with a behavioural FIFO read port
module tb_async_fifo_rd_ctrl;
   logic       rclk = 1'b0;
   logic       r_rstn;
   logic       rempty;
   logic       almost_empty;
   logic [7:0] rdata;
   logic       rinc;
   logic       en;
   logic       flush;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       flush_done;
   logic       low_water;
   logic [7:0] rd_cnt;
   logic [7:0] mem [256];
   logic [7:0] wp = 8'd0;
   logic [7:0] rp = 8'd0;
   int         pops = 0;
   int         p0;
   int         delivered = 0;
   int         errors = 0;
   int         checks = 0;
   always #5 rclk = ~rclk;
   assign rempty = (wp == rp);
   assign rdata  = mem[rp];
   always @(posedge rclk) if (rinc) begin
      rp   <= rp + 8'd1;
      pops <= pops + 1;
   end
   async_fifo_rd_ctrl #(.DATESIZE(8), .CNT_W(8)) dut (
      .rclk(rclk), .r_rstn(r_rstn), .rempty(rempty), .almost_empty(almost_empty),
      .rdata(rdata), .rinc(rinc), .en(en), .flush(flush), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .flush_done(flush_done),
      .low_water(low_water), .rd_cnt(rd_cnt)
   );
   task automatic tick();
      @(posedge rclk);
      #2;
   endtask
   task automatic push(input logic [7:0] d);
      mem[wp] = d;
      wp = wp + 8'd1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask
   task automatic chk_cnt(input string tag);
`ifdef FIFO_RD_CNT_EN
      chk(tag, 32'(rd_cnt), delivered & 255);
`else
      chk(tag, 32'(rd_cnt), 0);
`endif
   endtask
   initial begin
      r_rstn = 1'b0; en = 1'b1; m_ready = 1'b0; flush = 1'b0; almost_empty = 1'b0;
      for (int i = 1; i <= 5; i++) push(8'(i));
      #1;
      chk("rst_rinc_async", 32'(rinc), 0);
      repeat (2) tick();
      chk("rst_rinc", 32'(rinc), 0);
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_data", 32'(m_data), 0);
      chk("rst_low_water", 32'(low_water), 1);
      chk("rst_flush_done", 32'(flush_done), 0);
      chk_cnt("rst_cnt");
      en = 1'b0;
      r_rstn = 1'b1;
      tick();
      chk("idle_rinc", 32'(rinc), 0);
      chk("idle_valid", 32'(m_valid), 0);
      chk("low_water_copy0", 32'(low_water), 0);
      almost_empty = 1'b1;
      #1;
      chk("low_water_lag", 32'(low_water), 0);
      tick();
      chk("low_water_copy1", 32'(low_water), 1);
      en = 1'b1; m_ready = 1'b1;
      #1;
      chk("en_rinc", 32'(rinc), 1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("burst_valid", 32'(m_valid), 1);
         chk("burst_data", 32'(m_data), i);
      end
      delivered += 5;
      tick();
      chk("burst_end_valid", 32'(m_valid), 0);
      chk("burst_pops", pops, 5);
      chk_cnt("burst_cnt");
      m_ready = 1'b0;
      p0 = pops;
      for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
      repeat (6) tick();
      chk("bp_pops", pops - p0, 2);
      chk("bp_valid", 32'(m_valid), 1);
      chk("bp_hold", 32'(m_data), 32'h10);
      chk("bp_rinc", 32'(rinc), 0);
      m_ready = 1'b1;
      #1;
      chk("bp_release_rinc", 32'(rinc), 1);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("bp_valid_run", 32'(m_valid), 1);
         chk("bp_data_run", 32'(m_data), 32'h10 + k);
      end
      delivered += 8;
      tick();
      chk("bp_end_valid", 32'(m_valid), 0);
      chk("bp_total_pops", pops - p0, 8);
      repeat (3) begin
         tick();
         chk("empty_rinc", 32'(rinc), 0);
         chk("empty_valid", 32'(m_valid), 0);
      end
      push(8'hA5);
      #1;
      chk("single_rinc", 32'(rinc), 1);
      tick();
      chk("single_valid", 32'(m_valid), 1);
      chk("single_data", 32'(m_data), 32'hA5);
      chk("single_rinc_off", 32'(rinc), 0);
      delivered += 1;
      tick();
      chk("single_end_valid", 32'(m_valid), 0);
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(8'(8'h31 + i));
      repeat (3) tick();
      chk("pre_flush_valid", 32'(m_valid), 1);
      chk("pre_flush_data", 32'(m_data), 32'h31);
      chk("pre_flush_rinc", 32'(rinc), 0);
      p0 = pops;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_valid", 32'(m_valid), 0);
      chk("flush_done_early", 32'(flush_done), 0);
      #1;
      chk("flush_rinc", 32'(rinc), 1);
      repeat (3) begin
         tick();
         chk("flush_drain_done", 32'(flush_done), 0);
         chk("flush_drain_valid", 32'(m_valid), 0);
      end
      chk("flush_pops", pops - p0, 3);
      chk("flush_rinc_empty", 32'(rinc), 0);
      tick();
      chk("flush_done_pulse", 32'(flush_done), 1);
      chk("flush_done_valid", 32'(m_valid), 0);
      tick();
      chk("flush_done_clear", 32'(flush_done), 0);
      m_ready = 1'b1;
      #1;
      chk("post_flush_valid", 32'(m_valid), 0);
      chk_cnt("flush_cnt");
      for (int i = 0; i < 250; i++) begin
         push(8'(i));
         tick();
         chk("stream_valid", 32'(m_valid), 1);
         chk("stream_data", 32'(m_data), i);
      end
      delivered += 250;
      tick();
      chk("stream_end_valid", 32'(m_valid), 0);
      chk("total_pops", pops, 269);
      chk_cnt("wrap_cnt");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
